mem_xfer_writer: RTL and testbench

- Destination-side write engine for the memory-to-memory transfer datapath; the write-side counterpart to the source-side read/address-counter path.
- Accepts a stream of words over a valid/ready handshake and writes them to consecutive destination addresses starting at a loaded base.
- Counts the remaining words and pulses done when the programmed length has been written.
- Sits between the source read stage output and the destination memory write port.

---
 rtl/mem_xfer_writer.sv | 106 ++++++++++
 tb/tb_mem_xfer_writer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_writer.sv
// Destination-side write engine: accepts a word stream over valid/ready and writes it to
// consecutive addresses from a latched base, pulsing done after the programmed length.
module mem_xfer_writer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_written
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          words_d = '0;
          if (xfer_len != '0) begin
            addr_d      = dst_base;
            remaining_d = xfer_len;
            state_d     = StWrite;
          end else begin
            state_d = StDone;
          end
        end
      end
      StWrite: begin
        // in_ready is high for the whole state, so in_valid alone marks a handshake
        if (in_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          words_d     = words_q + LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign in_ready      = (state_q == StWrite);
  assign busy          = (state_q == StWrite);
  assign done          = (state_q == StDone);
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_mem_xfer_writer.sv
// Self-checking bench for mem_xfer_writer: table of transfers plus hand-written
// mid-transfer reset; expected writes flow through a scoreboard queue.
module tb_mem_xfer_writer;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 8;
  localparam int          MaxCyc = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic [LEN_W-1:0]  xfer_len = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_written;

  mem_xfer_writer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dst_base     (dst_base),
    .xfer_len     (xfer_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .busy         (busy),
    .done         (done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  len;
    logic [15:0] pat;           // in_valid per WRITE cycle, bit k = k-th cycle
    int          restart_at;    // WRITE cycle to pulse a stray start, -1 for none
    int          exp_done_cyc;  // negedges from start drive to done
    logic [7:0]  exp_last_addr;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   failures = 0;
  int   writes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t w;
    if (mem_we === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", 32'(mem_wdata), 32'(w.data));
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int  k = 0;
    int  n = 0;
    int  cyc;
    int  base_writes;
    wr_t w;
    base_writes = writes_seen;
    start    = 1'b1;
    dst_base = v.base;
    xfer_len = v.len;
    in_valid = 1'b1;  // offered with start: must not be consumed
    in_data  = 8'h55;
    @(negedge clk);
    cyc      = 1;
    start    = 1'b0;
    dst_base = 8'h00;
    xfer_len = 8'hFF;
    while (n < int'(v.len) && cyc < MaxCyc) begin
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_early_done"}, 32'(done), 32'd0);
      in_valid = v.pat[k % 16];
      in_data  = 8'(8'hA0 + n);
      if (k == v.restart_at) begin
        start    = 1'b1;
        dst_base = 8'h80;
        xfer_len = 8'd9;
      end
      if (in_valid) begin
        w.addr = 8'(v.base + n);
        w.data = 8'(8'hA0 + n);
        exp_q.push_back(w);
        n++;
      end
      k++;
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    in_valid = 1'b0;
    check({tag, "_done_cycle"}, 32'(cyc), 32'(v.exp_done_cyc));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_ready_at_done"}, 32'(in_ready), 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'(v.len));
    check({tag, "_we_at_done"}, 32'(mem_we), (v.len != 0) ? 32'd1 : 32'd0);
    if (v.len != 0) check({tag, "_last_addr"}, 32'(mem_addr), 32'(v.exp_last_addr));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_we"}, 32'(mem_we), 32'd0);
    check({tag, "_words_held"}, 32'(words_written), 32'(v.len));
    check({tag, "_write_count"}, 32'(writes_seen - base_writes), 32'(v.len));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    wr_t w;
    vecs[0] = '{8'h10, 8'd4, 16'hFFFF, -1, 5, 8'h13};  // basic
    vecs[1] = '{8'h10, 8'd4, 16'h0059, -1, 8, 8'h13};  // valid 1,0,0,1,1,0,1
    vecs[2] = '{8'hFE, 8'd3, 16'hFFFF, -1, 4, 8'h00};  // address wrap
    vecs[3] = '{8'h40, 8'd0, 16'hFFFF, -1, 1, 8'h00};  // zero length
    vecs[4] = '{8'h20, 8'd5, 16'hFFFF, 1, 6, 8'h24};   // stray start mid-transfer

    repeat (5) @(negedge clk);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (3) @(negedge clk);
    check("idle_ignore_ready", 32'(in_ready), 32'd0);
    check("idle_ignore_we", 32'(mem_we), 32'd0);
    in_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset after two of five words: no done, everything cleared.
    start    = 1'b1;
    dst_base = 8'h30;
    xfer_len = 8'd5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      in_data = 8'(8'hA0 + j);
      w.addr  = 8'(8'h30 + j);
      w.data  = 8'(8'hA0 + j);
      exp_q.push_back(w);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mrst_we", 32'(mem_we), 32'd0);
    check("mrst_words", 32'(words_written), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("mrst_no_done", 32'(done), 32'd0);
    end
    check("mrst_queue_empty", 32'(exp_q.size()), 32'd0);

    run_vec(vecs[0], "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
